// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and constants for the analog-mux select sequencer.
package mux_sel_sequencer_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (m[i-1]) idx = SEL_W'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Combinational channel search: next enabled channel above cur_i, plus lowest enabled.
module mux_next_ch
  import mux_sel_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  output logic [SEL_W-1:0]  next_o,
  output logic              found_o,
  output logic [SEL_W-1:0]  lowest_o
);

  // Descending scan so the last hit is the nearest set bit above cur_i.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (mask_i[i-1] && ((i - 1) > 32'(cur_i))) begin
        next_o  = SEL_W'(i - 1);
        found_o = 1'b1;
      end
    end
  end

  assign lowest_o = lowest_set(mask_i);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Scans enabled mux channels: registered complementary select, settle blanking, then a dwell sample window.
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned SETTLE  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   s,
  output logic [SEL_W-1:0]   sbar,
  output logic               sample_en,
  output logic               ch_done,
  output logic               frame_done,
  output logic               busy
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);
  localparam int unsigned CNT_W    = (DWELL_W > SETTLE_W) ? DWELL_W : SETTLE_W;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    s_q, s_d, sbar_q;
  logic [NUM_CH-1:0]   mask_q, mask_d, enc_mask;
  logic [DWELL_W-1:0]  dwell_q, dwell_d, dwell_eff;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    nxt_idx, low_idx;
  logic                nxt_found;
  logic                settle_last, dwell_last;

  // In IDLE the encoder looks at the live mask to pick the first channel at start;
  // while scanning it searches the latched mask above the current select.
  assign enc_mask = (state_q == ST_IDLE) ? mask : mask_q;

  mux_next_ch u_next_ch (
    .mask_i   (enc_mask),
    .cur_i    (s_q),
    .next_o   (nxt_idx),
    .found_o  (nxt_found),
    .lowest_o (low_idx)
  );

  assign dwell_eff   = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign settle_last = (cnt_q == CNT_W'(SETTLE - 1));
  assign dwell_last  = (cnt_q == CNT_W'(dwell_eff - 1'b1));

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    mask_d     = mask_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    ch_done    = 1'b0;
    frame_done = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (mask != '0)) begin
            mask_d  = mask;
            dwell_d = dwell;
            s_d     = low_idx;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_last) begin
            cnt_d   = '0;
            state_d = ST_DWELL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DWELL: begin
          if (dwell_last) begin
            ch_done = 1'b1;
            cnt_d   = '0;
            if (nxt_found) begin
              s_d     = nxt_idx;
              state_d = ST_SETTLE;
            end else begin
              // Frame end: the wrap re-latches from the live inputs, not mask_q.
              frame_done = 1'b1;
              if (cont && (mask != '0)) begin
                mask_d  = mask;
                dwell_d = dwell;
                s_d     = lowest_set(mask);
                state_d = ST_SETTLE;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      sbar_q  <= '1;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sbar_q  <= ~s_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s         = s_q;
  assign sbar      = sbar_q;
  assign sample_en = (state_q == ST_DWELL);
  assign busy      = (state_q != ST_IDLE);

endmodule
